wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Parameterised Wishbone B3 round-robin arbiter that lets `num_masters` Wishbone masters share one slave port. It sits between the CPU/debug/DMA masters and the slave-side bus mux (`wb_mux`) in the interconnect. Arbitration is registered. A grant is held for the whole bus cycle, as long as the granted master's `cyc` stays high.

## Interface
- `dw`, 32: data width.
- `aw`, 32: address width.
- `num_masters`, 2: number of masters, ≥2 (bench uses 5).
- `wb_clk_i` in 1: single clock, rising edge.
- `wb_rst_i` in 1: reset, asynchronous, active-high.
- `wbm_adr_i` in num_masters*aw: master addresses; master i at `[i*aw +: aw]` (same packing for all `wbm_*` vectors).
- `wbm_dat_i` in num_masters*dw: write data.
- `wbm_sel_i` in num_masters*dw/8: byte selects.
- `wbm_we_i`, `wbm_cyc_i`, `wbm_stb_i` in num_masters: write enable, cycle, strobe.
- `wbm_cti_i` in num_masters*3: cycle type.
- `wbm_bte_i` in num_masters*2: burst type.
- `wbm_dat_o` out num_masters*dw: read data; `wbs_dat_i` is replicated to every master.
- `wbm_ack_o`, `wbm_err_o`, `wbm_rty_o` out num_masters: per-master responses.
- `wbs_adr_o` out aw, `wbs_dat_o` out dw, `wbs_sel_o` out dw/8: slave-side address, write data, byte selects.
- `wbs_we_o`, `wbs_cyc_o`, `wbs_stb_o` out 1: slave-side write enable, cycle, strobe.
- `wbs_cti_o` out 3, `wbs_bte_o` out 2: slave-side cycle and burst type.
- `wbs_dat_i` in dw: slave read data.
- `wbs_ack_i`, `wbs_err_i`, `wbs_rty_i` in 1: slave responses.

## Operation
- State: `grant` (index, width clog2(num_masters), min 1), `active` (1 bit).
- Re-arbitration on every rising edge where `!active || !wbm_cyc_i[grant]`:
  - Search masters `grant+1, grant+2, …, grant` modulo num_masters; the search wraps, and the current holder is checked last.
  - First master with `cyc` high wins: `grant<=winner`, `active<=1`.
  - If no master requests: `active<=0`, `grant` unchanged.
- While `active && wbm_cyc_i[grant]`, no re-arbitration occurs. The grant is held across any number of strobes, bursts and wait states.
- Slave outputs are combinational from the granted master:
  - `adr`, `dat`, `sel`, `we`, `cti`, `bte` are passed through.
  - `wbs_cyc_o = active & wbm_cyc_i[grant]`.
  - `wbs_stb_o = active & wbm_cyc_i[grant] & wbm_stb_i[grant]`.
- Responses: `wbm_ack_o[i] = wbs_ack_i & active & (grant==i)`. `err` and `rty` are gated the same way, so non-granted masters never see a response.
- Non-granted masters simply wait with `cyc`/`stb` high; they are never signalled.

## Timing
- Reset (async assert, sync release): `grant=0`, `active=0`.
  - All of `wbs_cyc_o`, `wbs_stb_o`, `wbm_ack_o`, `wbm_err_o`, `wbm_rty_o` read 0 immediately.
  - Other slave outputs mirror master 0.
- Reset mid-transfer aborts the cycle at once: `wbs_cyc_o` falls in the same cycle reset asserts, and no ack is forwarded.
- Idle to first grant: `cyc` seen at edge N → `wbs_cyc_o` high after edge N, so the slave sees the request one cycle after the master.
- Release: the master drops `cyc` → re-arbitration at the next edge. There is exactly one dead cycle between back-to-back cycles of different masters.
- A master that drops `cyc` for one edge and reasserts does not keep the grant if any other master requests (fairness).
- Simultaneous requests from idle reset state: master 1 wins first (search starts at grant+1=1), then 2, 3, …, 0.
- Responses are zero-latency pass-through; single-cycle slave acks give one transfer per clock to the granted master.

## Test plan
- Reset: hold `wb_rst_i`=1 with `wbm_cyc_i`=5'b11111 → `wbs_cyc_o`=0, all `wbm_ack_o`=0. Release → `wbs_cyc_o`=1 one edge later with grant=1.
- Single master: only master 3 requests, read `adr`=0x100, slave acks with `dat`=0xDEADBEEF → `wbm_ack_o`=5'b01000, master 3 reads 0xDEADBEEF, `wbs_adr_o`=0x100.
- Round-robin: all 5 masters hold `cyc` and each drops it after one acked transfer → grant order 1,2,3,4,0,1. Each master completes one transfer per lap, with one idle cycle between them.
- Burst hold: master 2 runs an 8-beat incrementing burst (`cti`=3'b010, then 3'b111) while master 4 requests → all 8 acks go to master 2; master 4 gets the grant only after master 2's `cyc` falls.
- Error/retry routing: granted master 0, slave drives `err`, then `rty` → only `wbm_err_o[0]`, then only `wbm_rty_o[0]`, asserted.
- Async reset mid-burst: assert `wb_rst_i` between clock edges during master 1's burst → `wbs_cyc_o` and `wbm_ack_o` drop immediately. After release, arbitration restarts from grant=0.

Source files
------------

// File: rtl/wb_arbiter.sv
// Wishbone B3 round-robin arbiter: shares one slave port among num_masters masters.
// The grant is registered and held for as long as the granted master keeps cyc high.
module wb_arbiter #(
  parameter int dw          = 32,
  parameter int aw          = 32,
  parameter int num_masters = 2
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic [num_masters*aw-1:0]     wbm_adr_i,
  input  logic [num_masters*dw-1:0]     wbm_dat_i,
  input  logic [num_masters*(dw/8)-1:0] wbm_sel_i,
  input  logic [num_masters-1:0]        wbm_we_i,
  input  logic [num_masters-1:0]        wbm_cyc_i,
  input  logic [num_masters-1:0]        wbm_stb_i,
  input  logic [num_masters*3-1:0]      wbm_cti_i,
  input  logic [num_masters*2-1:0]      wbm_bte_i,
  output logic [num_masters*dw-1:0]     wbm_dat_o,
  output logic [num_masters-1:0]        wbm_ack_o,
  output logic [num_masters-1:0]        wbm_err_o,
  output logic [num_masters-1:0]        wbm_rty_o,
  output logic [aw-1:0]                 wbs_adr_o,
  output logic [dw-1:0]                 wbs_dat_o,
  output logic [dw/8-1:0]               wbs_sel_o,
  output logic                          wbs_we_o,
  output logic                          wbs_cyc_o,
  output logic                          wbs_stb_o,
  output logic [2:0]                    wbs_cti_o,
  output logic [1:0]                    wbs_bte_o,
  input  logic [dw-1:0]                 wbs_dat_i,
  input  logic                          wbs_ack_i,
  input  logic                          wbs_err_i,
  input  logic                          wbs_rty_i
);

  localparam int gw = (num_masters > 2) ? $clog2(num_masters) : 1;
  typedef logic [gw-1:0] grant_t;

  grant_t grant_q, grant_d;
  logic   active_q, active_d;
  logic   hold_s;
  int     idx_s;

  logic [aw-1:0]   adr_a [num_masters];
  logic [dw-1:0]   dat_a [num_masters];
  logic [dw/8-1:0] sel_a [num_masters];
  logic [2:0]      cti_a [num_masters];
  logic [1:0]      bte_a [num_masters];

  // Unpack the flat master vectors into per-master arrays
  always_comb begin
    for (int i = 0; i < num_masters; i++) begin
      adr_a[i] = wbm_adr_i[i*aw +: aw];
      dat_a[i] = wbm_dat_i[i*dw +: dw];
      sel_a[i] = wbm_sel_i[i*(dw/8) +: (dw/8)];
      cti_a[i] = wbm_cti_i[i*3 +: 3];
      bte_a[i] = wbm_bte_i[i*2 +: 2];
    end
  end

  assign hold_s = active_q & wbm_cyc_i[grant_q];

  // Round-robin search; scanning farthest-first lets the nearest requester after grant win
  always_comb begin
    grant_d  = grant_q;
    active_d = active_q;
    idx_s    = 0;
    if (!hold_s) begin
      active_d = 1'b0;
      for (int k = num_masters; k >= 1; k--) begin
        idx_s = (int'(grant_q) + k) % num_masters;
        if (wbm_cyc_i[grant_t'(idx_s)]) begin
          grant_d  = grant_t'(idx_s);
          active_d = 1'b1;
        end else begin
          grant_d  = grant_d;
          active_d = active_d;
        end
      end
    end else begin
      grant_d  = grant_q;
      active_d = active_q;
    end
  end

  // Grant and active state registers
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      grant_q  <= '0;
      active_q <= 1'b0;
    end else begin
      grant_q  <= grant_d;
      active_q <= active_d;
    end
  end

  // Slave-side pass-through from the granted master
  always_comb begin
    wbs_adr_o = adr_a[grant_q];
    wbs_dat_o = dat_a[grant_q];
    wbs_sel_o = sel_a[grant_q];
    wbs_we_o  = wbm_we_i[grant_q];
    wbs_cti_o = cti_a[grant_q];
    wbs_bte_o = bte_a[grant_q];
    wbs_cyc_o = hold_s;
    wbs_stb_o = hold_s & wbm_stb_i[grant_q];
  end

  // Responses reach only the granted master; read data goes to everyone
  always_comb begin
    wbm_dat_o = {num_masters{wbs_dat_i}};
    for (int i = 0; i < num_masters; i++) begin
      wbm_ack_o[i] = wbs_ack_i & active_q & (grant_q == grant_t'(i));
      wbm_err_o[i] = wbs_err_i & active_q & (grant_q == grant_t'(i));
      wbm_rty_o[i] = wbs_rty_i & active_q & (grant_q == grant_t'(i));
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter with five masters: vector table, directed
// corner-case sequences and randomized traffic against a round-robin reference model.
module tb_wb_arbiter;
  localparam int N  = 5;
  localparam int DW = 32;
  localparam int AW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*AW-1:0]   wbm_adr;
  logic [N*DW-1:0]   wbm_dat;
  logic [N*4-1:0]    wbm_sel;
  logic [N-1:0]      wbm_we, wbm_cyc, wbm_stb;
  logic [N*3-1:0]    wbm_cti;
  logic [N*2-1:0]    wbm_bte;
  logic [N*DW-1:0]   wbm_dat_o;
  logic [N-1:0]      wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [AW-1:0]     wbs_adr_o;
  logic [DW-1:0]     wbs_dat_o;
  logic [3:0]        wbs_sel_o;
  logic              wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [2:0]        wbs_cti_o;
  logic [1:0]        wbs_bte_o;
  logic [DW-1:0]     wbs_dat_i;
  logic              wbs_ack_i, wbs_err_i, wbs_rty_i;

  int errors = 0;
  int checks = 0;

  int m_grant;
  bit m_active;

  typedef struct {
    logic [N-1:0] cyc;
    logic         ack;
    logic         exp_cyc;
    logic [N-1:0] exp_ack;
  } vec_t;
  vec_t tbl [12];

  wb_arbiter #(.dw(DW), .aw(AW), .num_masters(N)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbm_adr_i(wbm_adr), .wbm_dat_i(wbm_dat), .wbm_sel_i(wbm_sel),
    .wbm_we_i(wbm_we), .wbm_cyc_i(wbm_cyc), .wbm_stb_i(wbm_stb),
    .wbm_cti_i(wbm_cti), .wbm_bte_i(wbm_bte),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_we_o(wbs_we_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
    .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: requesters listed in round-robin order starting after the holder; first one wins.
  function automatic void model_edge();
    int q[$];
    if (rst) begin
      m_grant  = 0;
      m_active = 1'b0;
    end else if (!(m_active && wbm_cyc[m_grant])) begin
      for (int d = 1; d <= N; d++)
        if (wbm_cyc[(m_grant + d) % N]) q.push_back((m_grant + d) % N);
      m_active = (q.size() > 0);
      if (q.size() > 0) m_grant = q[0];
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model();
    logic [N-1:0] e_ack, e_err, e_rty;
    logic owned;
    owned = m_active && wbm_cyc[m_grant];
    e_ack = '0; e_err = '0; e_rty = '0;
    if (m_active) begin
      e_ack[m_grant] = wbs_ack_i;
      e_err[m_grant] = wbs_err_i;
      e_rty[m_grant] = wbs_rty_i;
    end
    check("rnd_cyc", wbs_cyc_o, owned);
    check("rnd_stb", wbs_stb_o, owned && wbm_stb[m_grant]);
    check("rnd_adr", wbs_adr_o, wbm_adr[m_grant*AW +: AW]);
    check("rnd_wdat", wbs_dat_o, wbm_dat[m_grant*DW +: DW]);
    check("rnd_ctl", {wbs_sel_o, wbs_we_o, wbs_cti_o, wbs_bte_o},
          {wbm_sel[m_grant*4 +: 4], wbm_we[m_grant], wbm_cti[m_grant*3 +: 3], wbm_bte[m_grant*2 +: 2]});
    check("rnd_resp", {wbm_ack_o, wbm_err_o, wbm_rty_o}, {e_ack, e_err, e_rty});
    check("rnd_rdat", wbm_dat_o, {N{wbs_dat_i}});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wbm_cyc = '0; wbm_stb = '0; wbm_we = '0; wbm_cti = '0; wbm_bte = '0;
    wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_rty_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    wbm_dat = '0; wbm_sel = '0; wbs_dat_i = '0;
    for (int i = 0; i < N; i++) wbm_adr[i*AW +: AW] = 32'h0000_1000 * (i + 1);
    do_reset();

    // Reset held with every master requesting
    rst = 1'b1; wbm_cyc = 5'b11111; wbm_stb = 5'b11111; wbs_ack_i = 1'b1;
    tick(); tick();
    check("rst_cyc", wbs_cyc_o, 1'b0);
    check("rst_ack", wbm_ack_o, 5'b00000);
    check("rst_adr_m0", wbs_adr_o, 32'h0000_1000);
    rst = 1'b0; wbs_ack_i = 1'b0;
    #1 check("rel_cyc_pre", wbs_cyc_o, 1'b0);
    tick();
    check("rel_cyc_post", wbs_cyc_o, 1'b1);
    check("rel_grant1_adr", wbs_adr_o, 32'h0000_2000);

    // Round-robin table: each master drops cyc for one cycle after its ack
    tbl[0]  = '{5'b11111, 1'b1, 1'b0, 5'b00000};
    tbl[1]  = '{5'b11111, 1'b1, 1'b1, 5'b00010};
    tbl[2]  = '{5'b11101, 1'b0, 1'b0, 5'b00000};
    tbl[3]  = '{5'b11111, 1'b1, 1'b1, 5'b00100};
    tbl[4]  = '{5'b11011, 1'b0, 1'b0, 5'b00000};
    tbl[5]  = '{5'b11111, 1'b1, 1'b1, 5'b01000};
    tbl[6]  = '{5'b10111, 1'b0, 1'b0, 5'b00000};
    tbl[7]  = '{5'b11111, 1'b1, 1'b1, 5'b10000};
    tbl[8]  = '{5'b01111, 1'b0, 1'b0, 5'b00000};
    tbl[9]  = '{5'b11111, 1'b1, 1'b1, 5'b00001};
    tbl[10] = '{5'b11110, 1'b0, 1'b0, 5'b00000};
    tbl[11] = '{5'b11111, 1'b1, 1'b1, 5'b00010};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      wbm_cyc = tbl[i].cyc; wbm_stb = tbl[i].cyc; wbs_ack_i = tbl[i].ack;
      #1;
      check($sformatf("rr_cyc[%0d]", i), wbs_cyc_o, tbl[i].exp_cyc);
      check($sformatf("rr_ack[%0d]", i), wbm_ack_o, tbl[i].exp_ack);
      tick();
    end

    // Single master 3 read
    do_reset();
    wbm_cyc = 5'b01000; wbm_stb = 5'b01000;
    wbm_adr[3*AW +: AW] = 32'h0000_0100; wbs_dat_i = 32'hDEAD_BEEF;
    #1 check("single_pre_cyc", wbs_cyc_o, 1'b0);
    tick();
    wbs_ack_i = 1'b1;
    #1;
    check("single_ack", wbm_ack_o, 5'b01000);
    check("single_rdat", wbm_dat_o[3*DW +: DW], 32'hDEAD_BEEF);
    check("single_adr", wbs_adr_o, 32'h0000_0100);
    check("single_stb", wbs_stb_o, 1'b1);
    tick();

    // Burst hold: master 2 keeps the grant for 8 beats while master 4 waits
    do_reset();
    wbm_cyc = 5'b00100; wbm_stb = 5'b00100; wbm_cti[2*3 +: 3] = 3'b010;
    tick();
    wbm_cyc = 5'b10100; wbm_stb = 5'b10100;
    for (int b = 0; b < 8; b++) begin
      wbm_cti[2*3 +: 3] = (b == 7) ? 3'b111 : 3'b010;
      wbs_ack_i = 1'b1;
      #1;
      check($sformatf("burst_ack[%0d]", b), wbm_ack_o, 5'b00100);
      check($sformatf("burst_cti[%0d]", b), wbs_cti_o, (b == 7) ? 3'b111 : 3'b010);
      tick();
    end
    wbm_cyc = 5'b10000; wbm_stb = 5'b10000; wbs_ack_i = 1'b0;
    #1 check("burst_dead_cyc", wbs_cyc_o, 1'b0);
    tick();
    wbs_ack_i = 1'b1;
    #1 check("burst_m4_ack", wbm_ack_o, 5'b10000);
    tick();

    // Error and retry routing to master 0
    do_reset();
    wbm_cyc = 5'b00001; wbm_stb = 5'b00001;
    tick();
    wbs_err_i = 1'b1;
    #1 check("err_route", {wbm_err_o, wbm_ack_o, wbm_rty_o}, {5'b00001, 5'b00000, 5'b00000});
    wbs_err_i = 1'b0; wbs_rty_i = 1'b1;
    #1 check("rty_route", {wbm_rty_o, wbm_err_o}, {5'b00001, 5'b00000});
    wbs_rty_i = 1'b0;
    tick();

    // Async reset in the middle of master 1's burst
    do_reset();
    wbm_cyc = 5'b00010; wbm_stb = 5'b00010;
    tick();
    wbs_ack_i = 1'b1;
    #1 check("ar_pre_ack", wbm_ack_o, 5'b00010);
    #2 rst = 1'b1;
    #1;
    check("ar_cyc_drop", wbs_cyc_o, 1'b0);
    check("ar_ack_drop", wbm_ack_o, 5'b00000);
    tick();
    rst = 1'b0; wbs_ack_i = 1'b0; wbm_cyc = 5'b00110; wbm_stb = 5'b00110;
    tick();
    check("ar_restart_cyc", wbs_cyc_o, 1'b1);
    check("ar_restart_g1", wbs_adr_o, 32'h0000_2000);

    // Randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) wbm_cyc[i] = ~wbm_cyc[i];
        wbm_stb[i] = 1'($urandom_range(0, 1));
        wbm_we[i]  = 1'($urandom_range(0, 1));
        wbm_adr[i*AW +: AW] = $urandom();
        wbm_dat[i*DW +: DW] = $urandom();
        wbm_sel[i*4 +: 4] = 4'($urandom_range(0, 15));
        wbm_cti[i*3 +: 3] = 3'($urandom_range(0, 7));
        wbm_bte[i*2 +: 2] = 2'($urandom_range(0, 3));
      end
      wbs_dat_i = $urandom();
      wbs_ack_i = 1'($urandom_range(0, 1));
      wbs_err_i = 1'($urandom_range(0, 1));
      wbs_rty_i = 1'($urandom_range(0, 1));
      #1 check_model();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
